dram_write: RTL and testbench
=============================

Name: dram_write

Overview:
- Write-side controller for the external 32-bit asynchronous SRAM (20-bit word address, active-low ce/we/oe/be).
- It is the store counterpart to the instruction-fetch read controller.
- It accepts a level-held write request from the memory stage, latches address, data and byte enables, and sequences the setup, write-pulse and hold phases on the SRAM pins.
- It then pulses a one-cycle completion flag.

Parameters:
- PULSE_CYCLES, 2, number of cycles we is held low (legal 1..7).
- ADDR_LSB, 2, lowest byte-address bit mapped onto ram_addr[0].

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- write_ce  in  1  write request; level, held high by the requester until wfin is seen.
- address  in  32  byte address of the store.
- wdata  in  32  store data, already lane-aligned.
- byte_en  in  4  active-high lane enables; bit i covers wdata[8i+7:8i].
- ram_rdata  in  32  SRAM data bus as read back; used only by the optional feature.
- ram_addr  out  20  SRAM word address = latched address[ADDR_LSB+19:ADDR_LSB].
- ram_wdata  out  32  data to be driven onto the SRAM bus.
- ram_data_oe  out  1  1 = top level drives ram_wdata onto the tristate bus.
- ce  out  1  SRAM chip enable, active-low.
- we  out  1  SRAM write enable, active-low.
- oe  out  1  SRAM output enable, active-low.
- be_n  out  4  SRAM byte enables, active-low = ~latched byte_en.
- wfin  out  1  one-cycle write-complete pulse.
- wr_err  out  1  readback mismatch flag (optional feature; tied 0 otherwise).

Behaviour:
- All outputs are registered.
- Reset values: ce=1, we=1, oe=1, be_n=4'hF, ram_data_oe=0, ram_addr=0, ram_wdata=0, wfin=0, wr_err=0; state=IDLE; pulse counter=0.
- States: IDLE, SETUP, PULSE, HOLD, DONE, RELEASE.
- IDLE:
  - On write_ce=1 at an edge, latch address/wdata/byte_en.
  - If byte_en==0: go to DONE; no pin activity.
  - Otherwise: go to SETUP.
- SETUP (1 cycle): ce=0, we=1, oe=1, ram_data_oe=1, ram_addr/ram_wdata/be_n valid. Next state is PULSE.
- PULSE (PULSE_CYCLES cycles): we=0, all other pins unchanged. The counter counts 0..PULSE_CYCLES-1, then the state goes to HOLD.
- HOLD (1 cycle): we=1; ce, address, data and be_n are still driven. Next state is DONE.
- DONE (1 cycle):
  - wfin=1, ce=1, ram_data_oe=0, be_n=4'hF.
  - Next state is RELEASE.
- RELEASE: waits for write_ce=0, then goes to IDLE. This prevents a held request from writing twice.
- Latency: write_ce sampled high at edge k puts SETUP on the pins after edge k. wfin is high in the cycle after edge k+PULSE_CYCLES+2, which is 4 cycles after edge k for PULSE_CYCLES=2. A byte_en==0 write gives wfin after edge k+1.
- Inputs are ignored after the IDLE latch; changing them mid-write has no effect.
- Abort: write_ce=0 in SETUP/PULSE/HOLD causes the following:
  - The next state is IDLE.
  - we=1, ce=1, ram_data_oe=0 and be_n=4'hF after that edge.
  - wfin is never asserted for an aborted write; memory contents are undefined.
- rst mid-operation: all outputs return to reset values at the next edge. we must never be 0 in the cycle after rst is sampled.
- Invariants:
  - we=0 only while ce=0 and ram_data_oe=1.
  - oe=1 whenever ram_data_oe=1.
  - ram_addr/ram_wdata/be_n are stable from SETUP through HOLD.
- Back-to-back: write_ce must drop for at least one cycle between writes, so the minimum write period is PULSE_CYCLES+5 cycles.

Optional Feature:
- Macro: DRAM_WRITE_READBACK_EN.
- When defined, the sequence after HOLD is as follows:
  - State VERIFY (2 cycles): ram_data_oe=0, ce=0, oe=0, we=1, be_n unchanged.
  - On the second cycle, ram_rdata is compared with latched wdata on the enabled lanes only.
  - wr_err is set to 1 on mismatch and is sticky until rst.
  - Then the state goes to DONE. This adds 2 cycles of latency.
- When undefined: no VERIFY state, wr_err constant 0, ram_rdata unused.

Test Plan:
- Reset then idle: hold rst 2 cycles -> ce=we=oe=1, be_n=F, ram_data_oe=0, wfin=0. No change with write_ce=0 for 10 cycles.
- Full-word write, PULSE_CYCLES=2: address=0x8000_1234, wdata=0xDEADBEEF, byte_en=F, write_ce=1 at edge 0.
  - ram_addr=0x0048D and ce=0 after edge 0.
  - we=0 exactly after edges 1-2, we=1 after edge 3.
  - wfin=1 for one cycle after edge 4, then no second write while write_ce is still held.
- Byte write: byte_en=4'b0100 -> be_n=4'b1011 throughout SETUP..HOLD; byte_en=0 -> wfin after edge 1, ce/we never low.
- Abort: drop write_ce during the first PULSE cycle -> we=1, ce=1, ram_data_oe=0 next edge, no wfin. A new write then completes normally.
- Reset mid-write: assert rst during PULSE -> all outputs at reset values after that edge. The next request starts from SETUP.
- With DRAM_WRITE_READBACK_EN: model SRAM returns 0xDEADBE00 for a full-word write of 0xDEADBEEF -> wr_err=1 and wfin 2 cycles later than baseline. The same mismatch with byte_en=4'b1110 -> wr_err stays 0.

Source files
------------

// File: rtl/dram_write.sv
// dram_write: write-side sequencer for the external 32-bit asynchronous SRAM.
// Latches a level-held store request, drives the setup / write-pulse / hold
// phases on the SRAM pins, then pulses wfin for one cycle. It waits for the
// request to drop before accepting another. All outputs are registered.
//
// Optional build macro: DRAM_WRITE_READBACK_EN. When it is defined, a
// two-cycle VERIFY phase reads the word back after HOLD. A mismatch on any
// enabled lane sets the sticky wr_err flag.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   write_ce     level write request, held until wfin is seen
//   address      byte address of the store
//   wdata        lane-aligned store data
//   byte_en      active-high lane enables
//   ram_rdata    SRAM bus readback (readback build only)
//   ram_addr     SRAM word address
//   ram_wdata    data for the SRAM bus
//   ram_data_oe  1 = top level drives ram_wdata onto the bus
//   ce, we, oe   SRAM strobes, active-low
//   be_n         SRAM byte enables, active-low
//   wfin         one-cycle write-complete pulse
//   wr_err       sticky readback mismatch flag (0 without the macro)
module dram_write #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned ADDR_LSB     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_ce,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  input  logic [31:0] ram_rdata,
  output logic [19:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_data_oe,
  output logic        ce,
  output logic        we,
  output logic        oe,
  output logic [3:0]  be_n,
  output logic        wfin,
  output logic        wr_err
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned AW    = 20;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

`ifdef DRAM_WRITE_READBACK_EN
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, VERIFY, DONE, RELEASE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE, RELEASE} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] pcnt;
  logic             abort_c;
  logic             unused_bits;

  // Only the word-address slice of address is used. ram_rdata is used only by the readback build.
  assign unused_bits = ^{address, ram_rdata};

  // Dropping the request while the pins are active abandons the write.
  assign abort_c = !write_ce && (state == SETUP || state == PULSE || state == HOLD);

`ifdef DRAM_WRITE_READBACK_EN
  logic zero_q;
  logic rb_mismatch_c;

  // Compare only the lanes that were written. be_n still holds the enables during VERIFY.
  always_comb begin
    rb_mismatch_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!be_n[i] && (ram_rdata[8*i +: 8] != ram_wdata[8*i +: 8])) begin
        rb_mismatch_c = 1'b1;
      end
    end
  end
`endif

  // Sequencer. Each transition also loads the pin values of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pcnt        <= '0;
      ce          <= 1'b1;
      we          <= 1'b1;
      oe          <= 1'b1;
      be_n        <= 4'hF;
      ram_data_oe <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      wfin        <= 1'b0;
      wr_err      <= 1'b0;
`ifdef DRAM_WRITE_READBACK_EN
      zero_q      <= 1'b0;
`endif
    end else if (abort_c) begin
      state       <= IDLE;
      pcnt        <= '0;
      ce          <= 1'b1;
      we          <= 1'b1;
      ram_data_oe <= 1'b0;
      be_n        <= 4'hF;
      wfin        <= 1'b0;
    end else begin
      wfin <= 1'b0;
      case (state)
        IDLE: begin
          if (write_ce) begin
            ram_addr  <= address[ADDR_LSB +: AW];
            ram_wdata <= wdata;
            pcnt      <= '0;
`ifdef DRAM_WRITE_READBACK_EN
            zero_q    <= (byte_en == 4'h0);
`endif
            if (byte_en == 4'h0) begin
              // The empty write spends one quiet cycle in HOLD, with no pin
              // activity. This puts wfin one cycle after the request is accepted.
              state <= HOLD;
            end else begin
              state       <= SETUP;
              ce          <= 1'b0;
              we          <= 1'b1;
              oe          <= 1'b1;
              ram_data_oe <= 1'b1;
              be_n        <= ~byte_en;
            end
          end
        end
        SETUP: begin
          state <= PULSE;
          we    <= 1'b0;
        end
        PULSE: begin
          if (pcnt == PULSE_LAST) begin
            state <= HOLD;
            we    <= 1'b1;
            pcnt  <= '0;
          end else begin
            pcnt <= pcnt + CNT_W'(1);
          end
        end
        HOLD: begin
`ifdef DRAM_WRITE_READBACK_EN
          if (!zero_q) begin
            state       <= VERIFY;
            ram_data_oe <= 1'b0;
            oe          <= 1'b0;
          end else begin
            state       <= DONE;
            wfin        <= 1'b1;
            ce          <= 1'b1;
            ram_data_oe <= 1'b0;
            be_n        <= 4'hF;
          end
`else
          state       <= DONE;
          wfin        <= 1'b1;
          ce          <= 1'b1;
          ram_data_oe <= 1'b0;
          be_n        <= 4'hF;
`endif
        end
`ifdef DRAM_WRITE_READBACK_EN
        VERIFY: begin
          if (pcnt == CNT_W'(1)) begin
            if (rb_mismatch_c) begin
              wr_err <= 1'b1;
            end
            state <= DONE;
            pcnt  <= '0;
            wfin  <= 1'b1;
            ce    <= 1'b1;
            oe    <= 1'b1;
            be_n  <= 4'hF;
          end else begin
            pcnt <= pcnt + CNT_W'(1);
          end
        end
`endif
        DONE: begin
          state <= RELEASE;
        end
        RELEASE: begin
          // A request that is still held must not start a second write.
          if (!write_ce) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_write.sv
// tb_dram_write: randomized self-checking bench for dram_write. Expected pin
// waveforms come from a phase-timeline model that uses the cycle offset after
// the request is accepted. Build with DRAM_WRITE_READBACK_EN defined to
// exercise the readback phase.
module tb_dram_write;

  localparam int PULSE = 2;
  localparam int ALSB  = 2;
`ifdef DRAM_WRITE_READBACK_EN
  localparam int RB = 2;
`else
  localparam int RB = 0;
`endif

  logic        clk;
  logic        rst;
  logic        write_ce;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [31:0] ram_rdata;
  logic [19:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_data_oe;
  logic        ce;
  logic        we;
  logic        oe;
  logic [3:0]  be_n;
  logic        wfin;
  logic        wr_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic err_model = 1'b0;

  dram_write #(.PULSE_CYCLES(PULSE), .ADDR_LSB(ALSB)) dut (
    .clk(clk), .rst(rst), .write_ce(write_ce), .address(address),
    .wdata(wdata), .byte_en(byte_en), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_data_oe(ram_data_oe),
    .ce(ce), .we(we), .oe(oe), .be_n(be_n), .wfin(wfin), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [8:0] IDLE_PINS = {1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0};

  // Expected {ce,we,oe,ram_data_oe,be_n,wfin} at cycle n after acceptance.
  // Phases: setup at 0, pulse at 1..PULSE, hold at PULSE+1, verify after that,
  // and done at dlen.
  function automatic logic [8:0] expect_pins(input int n, input int dlen,
                                             input bit zero, input logic [3:0] be);
    logic       ce_e, we_e, oe_e, doe_e, wfin_e;
    logic [3:0] ben_e;
    ce_e = 1'b1; we_e = 1'b1; oe_e = 1'b1; doe_e = 1'b0; wfin_e = 1'b0; ben_e = 4'hF;
    if (n == dlen) begin
      wfin_e = 1'b1;
    end else if (n < dlen && !zero) begin
      ce_e  = 1'b0;
      ben_e = ~be;
      if (n <= PULSE + 1) begin
        doe_e = 1'b1;
        we_e  = !(n >= 1 && n <= PULSE);
      end else begin
        oe_e = 1'b0;
      end
    end
    return {ce_e, we_e, oe_e, doe_e, ben_e, wfin_e};
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // One complete write. The request is held for 'extra' cycles after done,
  // then released. Inputs are scrambled after acceptance.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] rd, input int extra, input string tag);
    int          dlen;
    bit          zero;
    logic [61:0] exp_v, got_v;
    zero = (be == 4'h0);
    dlen = zero ? 1 : PULSE + 2 + RB;
    address = a; wdata = d; byte_en = be; ram_rdata = rd; write_ce = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= dlen + extra + 2; n++) begin
      @(negedge clk);
      if (n == 0) begin
        address = $urandom; wdata = $urandom; byte_en = 4'($urandom);
      end
      if (n == dlen + extra) write_ce = 1'b0;
      if (n == dlen && !zero && RB != 0 && (((rd ^ d) & lane_mask(be)) != 32'h0))
        err_model = 1'b1;
      exp_v = {expect_pins(n, dlen, zero, be), err_model, a[ALSB +: 20], d};
      got_v = {ce, we, oe, ram_data_oe, be_n, wfin, wr_err, ram_addr, ram_wdata};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s cyc%0d: got pins=%b err=%b addr=%h data=%h, want pins=%b err=%b addr=%h data=%h",
                 tag, n, got_v[61:53], got_v[52], got_v[51:32], got_v[31:0],
                 exp_v[61:53], exp_v[52], exp_v[51:32], exp_v[31:0]);
      end
    end
  endtask

  task automatic test_reset();
    logic [61:0] got_v;
    rst = 1'b1; write_ce = 1'b0; address = '0; wdata = '0; byte_en = '0; ram_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got_v = {ce, we, oe, ram_data_oe, be_n, wfin, wr_err, ram_addr, ram_wdata};
    n_cmp++;
    if (got_v !== {IDLE_PINS, 1'b0, 52'h0}) begin
      n_bad++;
      $display("FAIL reset_values: got %h want %h", got_v, {IDLE_PINS, 1'b0, 52'h0});
    end
    rst = 1'b0;
    err_model = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ce, we, oe, ram_data_oe, be_n, wfin} !== IDLE_PINS) begin
        n_bad++;
        $display("FAIL idle_quiet cyc%0d: got %b want %b", i,
                 {ce, we, oe, ram_data_oe, be_n, wfin}, IDLE_PINS);
      end
    end
  endtask

  task automatic test_full_word();
    do_write(32'h8000_1234, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 3, "full_word");
  endtask

  task automatic test_byte_lanes();
    do_write(32'h0000_0F08, 32'h00AB_0000, 4'b0100, 32'h00AB_0000, 1, "byte_lane2");
    do_write(32'h0012_3450, 32'h1234_5678, 4'b0000, 32'h1234_5678, 2, "byte_none");
    do_write($urandom, $urandom, 4'b0011, 32'h0, 0, "half_low");
  endtask

  task automatic test_abort();
    logic [31:0] a, d;
    for (int j = 0; j <= PULSE + 1; j++) begin
      a = $urandom; d = $urandom;
      address = a; wdata = d; byte_en = 4'hF; ram_rdata = d; write_ce = 1'b1;
      @(posedge clk);
      for (int n = 0; n <= j; n++) begin
        @(negedge clk);
        n_cmp++;
        if ({ce, we, oe, ram_data_oe, be_n, wfin} !== expect_pins(n, PULSE + 2 + RB, 1'b0, 4'hF)) begin
          n_bad++;
          $display("FAIL abort_pre j%0d cyc%0d: got %b want %b", j, n,
                   {ce, we, oe, ram_data_oe, be_n, wfin}, expect_pins(n, PULSE + 2 + RB, 1'b0, 4'hF));
        end
      end
      write_ce = 1'b0;
      for (int n = 0; n < 5; n++) begin
        @(negedge clk);
        n_cmp++;
        if ({ce, we, oe, ram_data_oe, be_n, wfin} !== IDLE_PINS) begin
          n_bad++;
          $display("FAIL abort_idle j%0d cyc%0d: got %b want %b", j, n,
                   {ce, we, oe, ram_data_oe, be_n, wfin}, IDLE_PINS);
        end
      end
      do_write($urandom, $urandom, 4'hF, 32'h0, 1, "after_abort");
    end
  endtask

  task automatic test_reset_mid_write();
    logic [61:0] got_v;
    for (int j = 1; j <= PULSE; j++) begin
      address = $urandom; wdata = $urandom; byte_en = 4'hF; write_ce = 1'b1;
      @(posedge clk);
      repeat (j + 1) @(negedge clk);
      rst = 1'b1; write_ce = 1'b0;
      @(negedge clk);
      got_v = {ce, we, oe, ram_data_oe, be_n, wfin, wr_err, ram_addr, ram_wdata};
      n_cmp++;
      if (got_v !== {IDLE_PINS, 1'b0, 52'h0}) begin
        n_bad++;
        $display("FAIL reset_mid j%0d: got %h want %h", j, got_v, {IDLE_PINS, 1'b0, 52'h0});
      end
      rst = 1'b0;
      err_model = 1'b0;
      @(negedge clk);
      do_write($urandom, $urandom, 4'($urandom_range(1, 15)), 32'h0, 0, "after_reset");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, rd;
    logic [3:0]  be;
    for (int i = 0; i < 20; i++) begin
      d  = $urandom;
      be = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? (d ^ (32'h1 << $urandom_range(0, 31))) : d;
      do_write($urandom, d, be, rd, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_readback();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    err_model = 1'b0;
    // A bad low byte on a lane that is not enabled must not raise wr_err.
    do_write(32'h0000_0100, 32'hDEAD_BEEF, 4'b1110, 32'hDEAD_BE00, 1, "rb_masked");
    do_write(32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BE00, 1, "rb_mismatch");
    do_write(32'h0000_0108, 32'h0BAD_F00D, 4'hF, 32'h0BAD_F00D, 0, "rb_sticky");
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_byte_lanes();
    test_abort();
    test_reset_mid_write();
    test_back_to_back();
    test_readback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
